// File: rtl/uart_pkg.sv
// Shared UART / pad-link framing definitions.
// Both the pad transmitter and the receiver on the other board import this
// package, so the frame layout is defined in one place.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 564;  // 65 MHz / 115200
    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned PAD_FRAME_BYTES   = 2;
    localparam int unsigned PAD_SYNC_BIT      = 7;
    localparam int unsigned PAD_HI_BITS       = 5;
    localparam int unsigned PAD_POS_W         = 10;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Builds one pad-link byte; hi selects byte0 (sync flag set, y[9:5])
    // versus byte1 (sync flag clear, y[4:0]).
    function automatic logic [UART_DATA_W-1:0] pad_byte(input logic [PAD_POS_W-1:0] y,
                                                        input logic                 hi);
        logic [UART_DATA_W-1:0] b;
        b               = '0;
        b[PAD_SYNC_BIT] = hi;
        if (hi) begin
            b[PAD_HI_BITS-1:0] = y[PAD_POS_W-1:PAD_HI_BITS];
        end else begin
            b[PAD_HI_BITS-1:0] = y[PAD_HI_BITS-1:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART 8N1 serializer (LSB first), owns baud counter and bit FSM.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : accepted at an edge where ready is high; data is captured then
//   data       : byte to send
//   tx         : serial line from a flop, idle high
//   done       : high during the final clock of the stop bit
//   ready      : high when start will be accepted at the next edge
//                (idle, or final stop-bit clock so bytes chain with no gap)
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [UART_DATA_W-1:0] data,
    output logic                   tx,
    output logic                   done,
    output logic                   ready
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic                   bit_end_c;

    assign bit_end_c = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and next tx bit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;

        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (start) begin
                    state_d = TX_START;
                    tx_d    = 1'b0;
                    shreg_d = data;
                end
            end
            TX_START: begin
                if (bit_end_c) begin
                    state_d   = TX_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[UART_DATA_W-1:1]};
                        tx_d      = shreg_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = TX_START;
                        tx_d    = 1'b0;
                        shreg_d = data;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Look ahead one cycle so done/ready are flops yet line up with the last stop clock
        done_d  = (state_d == TX_STOP) && (cnt_d == CNT_LAST);
        ready_d = (state_d == TX_IDLE) || done_d;
    end

    assign tx    = tx_q;
    assign done  = done_q;
    assign ready = ready_q;

endmodule

// File: rtl/pad_pos_uart_tx.sv
// Pad-position link transmitter: on each enabled game tick, latches y_pad and
// sends it as two UART bytes (byte0 = sync + high bits, byte1 = low bits).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   timing_tick : one-cycle frame request
//   en          : transmit enable; gates ticks and clears a pending request
//   y_pad       : local pad top position
//   tx          : UART line, idle high
//   busy        : high from frame acceptance through the last stop bit
//   frame_done  : one-cycle pulse once byte1's stop bit has completed
module pad_pos_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 timing_tick,
    input  logic                 en,
    input  logic [PAD_POS_W-1:0] y_pad,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned    SEL_W    = $clog2(PAD_FRAME_BYTES + 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(PAD_FRAME_BYTES);

    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   pending_q, pending_d;
    logic [PAD_POS_W-1:0]   y_lat_q, y_lat_d;
    logic [SEL_W-1:0]       byte_sel_q, byte_sel_d;  // next byte index to launch
    logic                   tick_c;
    logic                   start_c;
    logic [UART_DATA_W-1:0] data_c;
    logic                   byte_done;
    logic                   byte_ready;

    assign tick_c = timing_tick & en;

    // Sequencer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            y_lat_q      <= '0;
            byte_sel_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            y_lat_q      <= y_lat_d;
            byte_sel_q   <= byte_sel_d;
        end
    end

    // Byte sequencing, pending-request handling and back-to-back frame chaining
    always_comb begin
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        pending_d    = pending_q;
        y_lat_d      = y_lat_q;
        byte_sel_d   = byte_sel_q;
        start_c      = 1'b0;
        data_c       = pad_byte(y_lat_q, byte_sel_q == '0);

        if (!busy_q) begin
            if (tick_c) begin
                busy_d     = 1'b1;
                y_lat_d    = y_pad;
                byte_sel_d = '0;
            end
        end else begin
            if (tick_c) begin
                pending_d = 1'b1;
            end
            if (byte_done && (byte_sel_q == SEL_LAST)) begin
                frame_done_d = 1'b1;
                pending_d    = 1'b0;
                // A tick in this last stop clock counts as pending too
                if (en && (pending_q || timing_tick)) begin
                    start_c    = 1'b1;
                    data_c     = pad_byte(y_pad, 1'b1);
                    y_lat_d    = y_pad;
                    byte_sel_d = SEL_W'(1);
                end else begin
                    busy_d     = 1'b0;
                    byte_sel_d = '0;
                end
            end else if (byte_ready && (byte_sel_q != SEL_LAST)) begin
                start_c    = 1'b1;
                byte_sel_d = byte_sel_q + SEL_W'(1);
            end
        end

        if (!en) begin
            pending_d = 1'b0;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_c),
        .data  (data_c),
        .tx    (tx),
        .done  (byte_done),
        .ready (byte_ready)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
